// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared tone constants, detector defaults and FSM state type
package tone_pkg;

    localparam int NOTE_COUNT = 8;
    localparam int HALF_W     = 16;

    // Same half-period constants the oscillator bank uses, in clk cycles.
    localparam logic [HALF_W-1:0] NOTE_HALF [0:NOTE_COUNT-1] = '{
        16'd15289, 16'd13621, 16'd12135, 16'd11454,
        16'd10204, 16'd9091,  16'd8099,  16'd7645
    };

    localparam int DEFAULT_TOL     = 8;
    localparam int DEFAULT_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_CANDIDATE,
        ST_LOCK
    } det_state_t;

endpackage

// File: rtl/pitch_detector_if.sv
// rtl/pitch_detector_if.sv - measurement/lock result bundle of the pitch detector
interface pitch_detector_if #(
    parameter int NOTES = 8,
    parameter int CNT_W = 17
);
    logic [CNT_W-1:0]         period;
    logic                     period_strobe;
    logic [$clog2(NOTES)-1:0] note_idx;
    logic                     note_valid;
    logic                     timeout;

    modport master (
        output period, period_strobe, note_idx, note_valid, timeout
    );

    modport slave (
        input period, period_strobe, note_idx, note_valid, timeout
    );
endinterface

// File: rtl/note_matcher.sv
// rtl/note_matcher.sv - combinational period to note-table matcher, lowest index wins
module note_matcher
    import tone_pkg::*;
#(
    parameter int NOTES = NOTE_COUNT,
    parameter int CNT_W = 17,
    parameter int TOL   = DEFAULT_TOL,
    parameter logic [HALF_W-1:0] HALF [0:NOTES-1] = NOTE_HALF
) (
    input  logic [CNT_W+1:0]         period,
    output logic                     match,
    output logic [$clog2(NOTES)-1:0] idx
);

    localparam int CW    = CNT_W + 2;
    localparam int IDX_W = $clog2(NOTES);

    logic [CW-1:0] twice;
    logic [CW-1:0] diff;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match = 1'b0;
        idx   = '0;
        twice = '0;
        diff  = '0;
        for (int i = NOTES - 1; i >= 0; i--) begin
            twice = CW'({HALF[i], 1'b0});
            diff  = (period >= twice) ? (period - twice) : (twice - period);
            if (diff <= CW'(TOL)) begin
                match = 1'b1;
                idx   = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pitch_detector.sv
// rtl/pitch_detector.sv - measures tone input period and locks onto a table note
module pitch_detector
    import tone_pkg::*;
#(
    parameter int NOTES   = NOTE_COUNT,
    parameter int CNT_W   = 17,
    parameter int TOL     = DEFAULT_TOL,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter logic [HALF_W-1:0] HALF [0:NOTES-1] = NOTE_HALF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    pitch_detector_if.master det
);

    localparam int IDX_W = $clog2(NOTES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(TIMEOUT - 1);

    logic s0, s1, s2;
    logic rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W+1:0] meas;
    logic             match;
    logic [IDX_W-1:0] m_idx;
    logic             expire;

    det_state_t       state, state_n;
    logic [IDX_W-1:0] cand_q, cand_n;
    logic [CNT_W-1:0] period_q, period_n;
    logic             strobe_q, strobe_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             valid_q, valid_n;
    logic             to_q, to_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= sig_in;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign rise = s1 & ~s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign meas = (CNT_W+2)'(cnt) + 1'b1;

    note_matcher #(
        .NOTES (NOTES),
        .CNT_W (CNT_W),
        .TOL   (TOL),
        .HALF  (HALF)
    ) u_matcher (
        .period (meas),
        .match  (match),
        .idx    (m_idx)
    );

    // The elapsed period reaches TIMEOUT on this edge; a coincident rise takes priority.
    assign expire = !rise && (cnt == CNT_EXP) && (state != ST_IDLE);

    always_comb begin
        state_n  = state;
        cand_n   = cand_q;
        period_n = period_q;
        strobe_n = 1'b0;
        idx_n    = idx_q;
        valid_n  = valid_q;
        to_n     = 1'b0;
        if (rise && state != ST_IDLE) begin
            period_n = meas[CNT_W-1:0];
            strobe_n = 1'b1;
        end
        case (state)
            ST_IDLE: begin
                if (rise) state_n = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (rise && match) begin
                    cand_n  = m_idx;
                    state_n = ST_CANDIDATE;
                end
            end
            ST_CANDIDATE: begin
                if (rise) begin
                    if (match && m_idx == cand_q) begin
                        valid_n = 1'b1;
                        idx_n   = m_idx;
                        state_n = ST_LOCK;
                    end else if (match) begin
                        cand_n = m_idx;
                    end else begin
                        state_n = ST_MEASURE;
                    end
                end
            end
            ST_LOCK: begin
                if (rise && !(match && m_idx == idx_q)) begin
                    valid_n = 1'b0;
                    if (match) begin
                        cand_n  = m_idx;
                        state_n = ST_CANDIDATE;
                    end else begin
                        state_n = ST_MEASURE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (expire) begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
            to_n    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cand_q   <= '0;
            period_q <= '0;
            strobe_q <= 1'b0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_n;
            cand_q   <= cand_n;
            period_q <= period_n;
            strobe_q <= strobe_n;
            idx_q    <= idx_n;
            valid_q  <= valid_n;
            to_q     <= to_n;
        end
    end

    assign det.period        = period_q;
    assign det.period_strobe = strobe_q;
    assign det.note_idx      = idx_q;
    assign det.note_valid    = valid_q;
    assign det.timeout       = to_q;

endmodule

// File: tb/tb_pitch_detector.sv
// tb/tb_pitch_detector.sv - randomized model-checked bench for pitch_detector
module tb_pitch_detector;

    localparam int HI = 6;

    typedef struct {
        int per;
        int valid;
        int idx;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic sig_a = 1'b0;
    logic sig_b = 1'b0;

    int checks = 0;
    int failures = 0;

    int tbl [2][8] = '{'{15289, 13621, 12135, 11454, 10204, 9091, 8099, 7645},
                       '{60, 53, 47, 44, 40, 36, 32, 30}};
    int tol_v [2] = '{8, 2};
    int tmo_v [2] = '{65535, 300};

    bit       armed [2];
    bit       candv [2];
    bit       locked [2];
    int       cand [2];
    int       note [2];
    int       last [2];
    int       cyc [2];
    int       eper [2];
    bit [3:0] hist [2];

    ev_t slog_a[$];
    ev_t slog_b[$];
    int  tlog_a[$];
    int  tlog_b[$];

    pitch_detector_if #(.NOTES(8), .CNT_W(17)) ifa ();
    pitch_detector_if #(.NOTES(8), .CNT_W(17)) ifb ();

    pitch_detector dut_a (
        .clk    (clk),
        .rst_n  (rst_a),
        .sig_in (sig_a),
        .det    (ifa)
    );

    pitch_detector #(
        .NOTES   (8),
        .CNT_W   (17),
        .TOL     (2),
        .TIMEOUT (300),
        .HALF    ('{16'd60, 16'd53, 16'd47, 16'd44, 16'd40, 16'd36, 16'd32, 16'd30})
    ) dut_b (
        .clk    (clk),
        .rst_n  (rst_b),
        .sig_in (sig_b),
        .det    (ifb)
    );

    always #5 clk = ~clk;

    task automatic cmp(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit lookup(int u, int g, output int idx);
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            int d;
            d = g - 2 * tbl[u][i];
            if (d < 0) d = -d;
            if (d <= tol_v[u]) begin
                idx = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Model: a rise reaching the FSM at edge k is the input rising between samples k-3 and k-2.
    task automatic step(int u, logic rst, logic sig, int d_per, int d_str, int d_idx, int d_val, int d_to);
        int  e_str, e_to, mi, g;
        bit  r, m;
        ev_t e;
        string pfx;
        pfx = (u == 0) ? "a_" : "b_";
        if (!rst) begin
            armed[u] = 0; candv[u] = 0; locked[u] = 0;
            note[u] = 0; eper[u] = 0; cyc[u] = 0;
            hist[u] = {3'b000, sig};
            cmp({pfx, "rst_period"}, d_per, 0);
            cmp({pfx, "rst_strobe"}, d_str, 0);
            cmp({pfx, "rst_idx"}, d_idx, 0);
            cmp({pfx, "rst_valid"}, d_val, 0);
            cmp({pfx, "rst_timeout"}, d_to, 0);
            return;
        end
        cyc[u]++;
        r = hist[u][2] & ~hist[u][3];
        e_str = 0;
        e_to = 0;
        if (r) begin
            if (!armed[u]) begin
                armed[u] = 1;
            end else begin
                g = cyc[u] - last[u];
                eper[u] = g;
                e_str = 1;
                m = lookup(u, g, mi);
                if (locked[u]) begin
                    if (!(m && mi == note[u])) begin
                        locked[u] = 0; candv[u] = m; cand[u] = mi;
                    end
                end else if (candv[u] && m && mi == cand[u]) begin
                    locked[u] = 1; note[u] = mi; candv[u] = 0;
                end else begin
                    candv[u] = m; cand[u] = mi;
                end
            end
            last[u] = cyc[u];
        end else if (armed[u] && cyc[u] - last[u] == tmo_v[u]) begin
            e_to = 1;
            armed[u] = 0; locked[u] = 0; candv[u] = 0;
        end
        cmp({pfx, "period"}, d_per, eper[u]);
        cmp({pfx, "strobe"}, d_str, e_str);
        cmp({pfx, "note_idx"}, d_idx, note[u]);
        cmp({pfx, "note_valid"}, d_val, int'(locked[u]));
        cmp({pfx, "timeout"}, d_to, e_to);
        if (d_str != 0) begin
            e.per = d_per; e.valid = d_val; e.idx = d_idx; e.cyc = cyc[u];
            if (u == 0) slog_a.push_back(e); else slog_b.push_back(e);
        end
        if (d_to != 0) begin
            if (u == 0) tlog_a.push_back(cyc[u]); else tlog_b.push_back(cyc[u]);
        end
        hist[u] = {hist[u][2:0], sig};
    endtask

    always @(negedge clk) step(0, rst_a, sig_a, int'(ifa.period), int'(ifa.period_strobe),
                               int'(ifa.note_idx), int'(ifa.note_valid), int'(ifa.timeout));
    always @(negedge clk) step(1, rst_b, sig_b, int'(ifb.period), int'(ifb.period_strobe),
                               int'(ifb.note_idx), int'(ifb.note_valid), int'(ifb.timeout));

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(int u, logic v);
        if (u == 0) sig_a = v; else sig_b = v;
    endtask

    // One rising edge per call, spaced exactly p cycles from the previous call's edge.
    task automatic pulse(int u, int p);
        drive(u, 1'b0);
        wait_cyc(p - HI);
        drive(u, 1'b1);
        wait_cyc(HI);
    endtask

    task automatic exp_ev(int u, string nm, int n0, int per, int v, int idx);
        ev_t e;
        int  sz;
        sz = (u == 0) ? slog_a.size() : slog_b.size();
        cmp({nm, "_count"}, sz, n0 + 1);
        if (sz > 0) begin
            e = (u == 0) ? slog_a[sz-1] : slog_b[sz-1];
            cmp({nm, "_period"}, e.per, per);
            cmp({nm, "_valid"}, e.valid, v);
            if (v != 0) cmp({nm, "_idx"}, e.idx, idx);
        end
    endtask

    task automatic lit_zero(string nm);
        cmp({nm, "_period"}, int'(ifb.period), 0);
        cmp({nm, "_strobe"}, int'(ifb.period_strobe), 0);
        cmp({nm, "_idx"}, int'(ifb.note_idx), 0);
        cmp({nm, "_valid"}, int'(ifb.note_valid), 0);
        cmp({nm, "_timeout"}, int'(ifb.timeout), 0);
    endtask

    task automatic run_a();
        int n;
        pulse(0, 15290);
        cmp("a_arm_only", slog_a.size(), 0);
        n = slog_a.size(); pulse(0, 15290); exp_ev(0, "a_cand", n, 15290, 0, 0);
        n = slog_a.size(); pulse(0, 15298); exp_ev(0, "a_lock_tol", n, 15298, 1, 7);
        drive(0, 1'b0);
        wait_cyc(20);
    endtask

    task automatic run_b();
        int n, nt, ls, k, rep, p;
        pulse(1, 94);
        cmp("b_arm_only", slog_b.size(), 0);
        n = slog_b.size(); pulse(1, 94); exp_ev(1, "b_e2", n, 94, 0, 0);
        n = slog_b.size(); pulse(1, 94); exp_ev(1, "b_e3", n, 94, 1, 2);
        n = slog_b.size(); pulse(1, 120); exp_ev(1, "b_n0a", n, 120, 0, 0);
        n = slog_b.size(); pulse(1, 120); exp_ev(1, "b_n0b", n, 120, 1, 0);
        n = slog_b.size(); pulse(1, 122); exp_ev(1, "b_tol_in", n, 122, 1, 0);
        n = slog_b.size(); pulse(1, 123); exp_ev(1, "b_tol_out", n, 123, 0, 0);
        n = slog_b.size(); pulse(1, 120); exp_ev(1, "b_after_drop", n, 120, 0, 0);
        n = slog_b.size(); pulse(1, 94); exp_ev(1, "b_sw_c", n, 94, 0, 0);
        n = slog_b.size(); pulse(1, 94); exp_ev(1, "b_sw_l", n, 94, 1, 2);
        n = slog_b.size(); pulse(1, 72); exp_ev(1, "b_n5a", n, 72, 0, 0);
        n = slog_b.size(); pulse(1, 72); exp_ev(1, "b_n5b", n, 72, 1, 5);

        nt = tlog_b.size();
        ls = slog_b[slog_b.size()-1].cyc;
        drive(1, 1'b0);
        wait_cyc(310);
        cmp("b_silence_count", tlog_b.size(), nt + 1);
        if (tlog_b.size() > 0) cmp("b_silence_delay", tlog_b[tlog_b.size()-1] - ls, 300);
        cmp("b_silence_valid", int'(ifb.note_valid), 0);
        n = slog_b.size(); pulse(1, 94);
        cmp("b_rearm_only", slog_b.size(), n);
        n = slog_b.size(); pulse(1, 94); exp_ev(1, "b_re2", n, 94, 0, 0);

        nt = tlog_b.size();
        n = slog_b.size(); pulse(1, 300); exp_ev(1, "b_tie", n, 300, 0, 0);
        cmp("b_tie_no_timeout", tlog_b.size(), nt);
        n = slog_b.size(); pulse(1, 301);
        cmp("b_over_timeout", tlog_b.size(), nt + 1);
        cmp("b_over_no_strobe", slog_b.size(), n);
        n = slog_b.size(); pulse(1, 94); exp_ev(1, "b_ov2", n, 94, 0, 0);
        n = slog_b.size(); pulse(1, 94); exp_ev(1, "b_ov3", n, 94, 1, 2);

        drive(1, 1'b0);
        wait_cyc(20);
        #1 rst_b = 1'b0;
        #1 lit_zero("b_async_rst");
        wait_cyc(3);
        @(negedge clk);
        #1 rst_b = 1'b1;
        n = slog_b.size(); pulse(1, 94);
        cmp("b_post_rst_arm", slog_b.size(), n);
        n = slog_b.size(); pulse(1, 94); exp_ev(1, "b_pr2", n, 94, 0, 0);
        n = slog_b.size(); pulse(1, 94); exp_ev(1, "b_pr3", n, 94, 1, 2);

        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    k = $urandom_range(0, 7);
                    rep = $urandom_range(1, 3);
                    for (int j = 0; j < rep; j++) begin
                        p = 2 * tbl[1][k] + $urandom_range(0, 6) - 3;
                        pulse(1, p);
                    end
                end
                2: pulse(1, $urandom_range(12, 200));
                default: pulse(1, $urandom_range(295, 305));
            endcase
        end
        drive(1, 1'b0);
        wait_cyc(20);
    endtask

    initial begin
        wait_cyc(3);
        @(negedge clk);
        #1;
        lit_zero("b_reset_state");
        cmp("a_reset_valid", int'(ifa.note_valid), 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        fork
            run_a();
            run_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pitch_detector.md
# pitch_detector

Receive-side decoder for the square-wave tone oscillators. It takes one asynchronous 1-bit tone input, such as a raw oscillator output or the mixed `pwmout` from another board. It measures the period between rising edges in `clk` cycles and matches that period against the shared eight-note half-period table. It reports which note is present once two consecutive periods agree. It sits beside the oscillator bank in the top level, and its outputs drive LEDs or feed back into mixing logic.

## Interface
- `NOTES`, 8, number of entries in the note table; `note_idx` width is `$clog2(NOTES)`.
- `CNT_W`, 17, width of the period counter and of `period`.
- `TOL`, 8, allowed absolute deviation in cycles between a measured period and `2*HALF[i]`.
- `TIMEOUT`, 65535, cycles without a rising edge before lock is dropped; must be < `2**CNT_W`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `sig_in`  in  1  asynchronous tone input.
- `period`  out  `CNT_W`  last measured rising-to-rising period, in cycles.
- `period_strobe`  out  1  one-cycle pulse when `period` updates.
- `note_idx`  out  `$clog2(NOTES)`  index of the locked note.
- `note_valid`  out  1  high while locked to `note_idx`.
- `timeout`  out  1  one-cycle pulse when `TIMEOUT` expires.

## Operation
- Input conditioning: a 2-FF synchronizer, then a registered copy for rising-edge detect; `rise = s1 & ~s2`.
- Counter `cnt`:
  - Cleared to 0 on a `rise` cycle; otherwise increments.
  - Saturates at `TIMEOUT`.
  - The measured period at a `rise` is `cnt+1`.
- Matcher:
  - `hit[i] = |(cnt+1) - 2*HALF[i]| <= TOL`.
  - The lowest hit index wins.
  - `match` = any hit.
  - Compare with at least `CNT_W+1`-bit unsigned arithmetic and no wrap.
- FSM states:
  - `IDLE`: no reference edge. A `rise` moves to `MEASURE` and does not update `period`.
  - `MEASURE`: on `rise`, register `period` and pulse `period_strobe`.
    - If `match`, store `cand_idx` and go to `CANDIDATE`.
    - Otherwise stay in `MEASURE`.
  - `CANDIDATE`: on `rise`, update `period` and strobe.
    - If `match` and the index equals `cand_idx`, assert `note_valid`, set `note_idx`, and go to `LOCK`.
    - If `match` with a different index, store the new `cand_idx` and stay in `CANDIDATE`.
    - If no `match`, go to `MEASURE`.
  - `LOCK`: on `rise`, update `period` and strobe.
    - Same index: stay in `LOCK`.
    - Different matched index: drop `note_valid`, store the new `cand_idx`, go to `CANDIDATE`.
    - No match: drop `note_valid`, go to `MEASURE`.
  - Any state except `IDLE`: when `cnt` reaches `TIMEOUT` with no `rise`, pulse `timeout`, drop `note_valid`, go to `IDLE`.
- Simultaneous events: if `rise` and timeout expiry occur in the same cycle, `rise` wins and the timeout is not taken.
- Reset values: `period=0`, `period_strobe=0`, `note_idx=0`, `note_valid=0`, `timeout=0`, FSM in `IDLE`, `cnt=0`, synchronizer flops 0.
- Reset mid-measurement discards the partial period. The first edge after reset only arms the FSM.
- `note_idx` holds its last value while `note_valid=0`.

## Timing
- Latency from a `sig_in` rising transition to `rise` is 2–3 cycles because of the synchronizer.
- `period`, `period_strobe`, `note_idx` and `note_valid` are all registered and update together, 1 cycle after `rise`.
- Lock takes 3 rising edges after `IDLE`: arm, candidate, confirm.
- Dropping lock on a bad period takes 1 edge. Dropping lock on silence happens `TIMEOUT` cycles after the last `rise`, plus 1 cycle.
- Throughput: one measurement per input period. Periods shorter than 4 cycles are not required to be measured.

## Structure
- Shared package `tone_pkg` holds:
  - `NOTE_HALF[0:7] = {15289,13621,12135,11454,10204,9091,8099,7645}`, the same constants the oscillators use.
  - The FSM state enum.
  - The default `TOL` and `TIMEOUT` values.
- Sub-module `note_matcher`: a purely combinational period → (`match`, `idx`) comparator over the table, reusable by later blocks.
- Synchronizer and edge detect stay inline.

## Test plan
- Reset, then a square wave with half-period 12135 → no strobe at edge 1. At edge 2: `period=24270`, strobe, `note_valid=0`. At edge 3: `note_valid=1`, `note_idx=2`.
- Locked on note 0 (period 30578), then period 30586 → stays locked. Then period 30587 → `note_valid` falls with that strobe and the FSM is in `MEASURE`.
- Locked on note 2, switch to half-period 9091 → `note_valid` drops on the first 18182 period and rises with `note_idx=5` on the next.
- Locked, then `sig_in` held low → `timeout` pulses exactly 65535 cycles after the last `rise`, plus 1, and `note_valid=0`. The next edge only arms.
- `rst_n` pulsed low mid-period while locked → all outputs are 0 immediately (asynchronous). Lock needs 3 fresh edges.
- Input edge on the same cycle `cnt` hits `TIMEOUT`, with `TIMEOUT` lowered to 40000 and period 40000 → strobe with `period=40000`, no `timeout` pulse.
